sram_controller: RTL and testbench

Memory-side responder for the pipeline's MEM stage: accepts one 32-bit word read or write request at a time and services it on an external 16-bit asynchronous SRAM as two half-word accesses. It sits between the EXE/MEM pipeline register outputs (read enable, write enable, ALU-result address, store value) and the SRAM pins. It returns `ready`, which the core ORs into its freeze so every pipeline register holds while an access is in flight.

---
 rtl/sram_pkg.sv | 20 ++
 rtl/sram_controller_if.sv | 30 +++
 rtl/sram_wait_counter.sv | 37 +++
 rtl/sram_controller.sv | 140 ++++++++++++++
 tb/tb_sram_controller.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: the access state
// machine encoding, the default data-memory base address and the half-word
// select constants used to form the SRAM address LSB.
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } sram_state_t;

    localparam int DEFAULT_BASE_ADDR = 1024;

    localparam logic LO = 1'b0;
    localparam logic HI = 1'b1;

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side request/response bundle of the SRAM controller. The master is
// the EXE/MEM pipeline register side, the slave is the controller.
interface sram_controller_if;

    logic        MEMread;
    logic        MEMwrite;
    logic [31:0] address;
    logic [31:0] data;
    logic [31:0] MEM_result;
    logic        ready;

    modport master (
        output MEMread,
        output MEMwrite,
        output address,
        output data,
        input  MEM_result,
        input  ready
    );

    modport slave (
        input  MEMread,
        input  MEMwrite,
        input  address,
        input  data,
        output MEM_result,
        output ready
    );

endinterface

// File: rtl/sram_wait_counter.sv
// Per-state wait counter: counts 0..WAIT_CYCLES-1 while enabled and is
// cleared whenever the controller changes state. 'last' marks the final wait
// cycle of a state; 'near_last' marks the cycle before it, which lets the
// controller register the write strobe release one cycle ahead.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last,
    output logic near_last
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_VALUE = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] NEAR_VALUE = CW'((WAIT_CYCLES >= 2) ? WAIT_CYCLES - 2 : 0);
    localparam logic          HAS_NEAR   = (WAIT_CYCLES >= 2);

    logic [CW-1:0] count;

    // Count wait cycles inside a state, restarting from zero on every state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign last      = (count == LAST_VALUE);
    assign near_last = HAS_NEAR && (count == NEAR_VALUE);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage SRAM controller: services one 32-bit word read or write at a time
// as two 16-bit accesses on an asynchronous SRAM (low half first). All SRAM
// pins are registered; 'ready' is combinational so the pipeline freezes in the
// same cycle a request appears.
module sram_controller
    import sram_pkg::*;
#(
    parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_DQ_out,
    input  logic [15:0]        SRAM_DQ_in,
    output logic               SRAM_DQ_oe,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N
);

    // With a single wait cycle the only cycle of a write state is also its
    // last one, so the strobe never goes low.
    localparam logic WE_ENTRY = (WAIT_CYCLES == 1) ? 1'b1 : 1'b0;

    sram_state_t        state;
    logic [31:0]        offset;
    logic [SRAM_AW-2:0] word_index;
    logic [15:0]        write_hi;
    logic [15:0]        capture_lo;
    logic               has_request;
    logic               in_access;
    logic               state_change;
    logic               wait_last;
    logic               wait_near_last;
    logic               unused_offset_bits;

    // Word index relative to the data-memory base; high bits beyond the SRAM
    // size are dropped so out-of-range addresses simply wrap.
    assign offset             = bus.address - 32'(BASE_ADDR);
    assign word_index         = offset[SRAM_AW:2];
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    assign has_request  = bus.MEMread | bus.MEMwrite;
    assign in_access    = (state == RD_LO) || (state == RD_HI) ||
                          (state == WR_LO) || (state == WR_HI);
    assign state_change = ((state == IDLE) && has_request) ||
                          (in_access && wait_last) ||
                          (state == DONE);

    assign bus.ready = ((state == IDLE) && !has_request) || (state == DONE);

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_change),
        .enable    (in_access),
        .last      (wait_last),
        .near_last (wait_near_last)
    );

    // Access sequencer: walks the half-word states and registers every SRAM pin
    // and the read result so nothing combinational reaches the pads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            SRAM_ADDR      <= '0;
            SRAM_DQ_out    <= '0;
            SRAM_DQ_oe     <= 1'b0;
            SRAM_WE_N      <= 1'b1;
            SRAM_OE_N      <= 1'b1;
            write_hi       <= '0;
            capture_lo     <= '0;
            bus.MEM_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.MEMwrite) begin
                        state       <= WR_LO;
                        SRAM_ADDR   <= {word_index, LO};
                        SRAM_DQ_out <= bus.data[15:0];
                        write_hi    <= bus.data[31:16];
                        SRAM_DQ_oe  <= 1'b1;
                        SRAM_WE_N   <= WE_ENTRY;
                        SRAM_OE_N   <= 1'b1;
                    end else if (bus.MEMread) begin
                        state      <= RD_LO;
                        SRAM_ADDR  <= {word_index, LO};
                        SRAM_DQ_oe <= 1'b0;
                        SRAM_WE_N  <= 1'b1;
                        SRAM_OE_N  <= 1'b0;
                    end
                end
                RD_LO: begin
                    if (wait_last) begin
                        state      <= RD_HI;
                        capture_lo <= SRAM_DQ_in;
                        SRAM_ADDR  <= {SRAM_ADDR[SRAM_AW-1:1], HI};
                    end
                end
                RD_HI: begin
                    if (wait_last) begin
                        state          <= DONE;
                        SRAM_OE_N      <= 1'b1;
                        bus.MEM_result <= {SRAM_DQ_in, capture_lo};
                    end
                end
                WR_LO: begin
                    if (wait_last) begin
                        state       <= WR_HI;
                        SRAM_ADDR   <= {SRAM_ADDR[SRAM_AW-1:1], HI};
                        SRAM_DQ_out <= write_hi;
                        SRAM_WE_N   <= WE_ENTRY;
                    end else if (wait_near_last) begin
                        SRAM_WE_N <= 1'b1;
                    end
                end
                WR_HI: begin
                    if (wait_last) begin
                        state      <= DONE;
                        SRAM_DQ_oe <= 1'b0;
                        SRAM_WE_N  <= 1'b1;
                    end else if (wait_near_last) begin
                        SRAM_WE_N <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: one instance with the default two wait
// cycles backed by a writable SRAM model, and one with a single wait cycle
// backed by a preloaded read-only model for back-to-back reads.
module tb_sram_controller;
    import sram_pkg::*;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    sram_controller_if bus1 ();
    sram_controller_if bus2 ();

    logic [17:0] sram1_addr;
    logic [15:0] sram1_dq_out;
    logic [15:0] sram1_dq_in;
    logic        sram1_dq_oe;
    logic        sram1_we_n;
    logic        sram1_oe_n;

    logic [17:0] sram2_addr;
    logic [15:0] sram2_dq_out;
    logic [15:0] sram2_dq_in;
    logic        sram2_dq_oe;
    logic        sram2_we_n;
    logic        sram2_oe_n;

    logic [15:0] mem1 [256];
    logic [15:0] mem2 [256];

    sram_controller #(
        .BASE_ADDR   (1024),
        .SRAM_AW     (18),
        .WAIT_CYCLES (2)
    ) dut1 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus1.slave),
        .SRAM_ADDR   (sram1_addr),
        .SRAM_DQ_out (sram1_dq_out),
        .SRAM_DQ_in  (sram1_dq_in),
        .SRAM_DQ_oe  (sram1_dq_oe),
        .SRAM_WE_N   (sram1_we_n),
        .SRAM_OE_N   (sram1_oe_n)
    );

    sram_controller #(
        .BASE_ADDR   (1024),
        .SRAM_AW     (18),
        .WAIT_CYCLES (1)
    ) dut2 (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus2.slave),
        .SRAM_ADDR   (sram2_addr),
        .SRAM_DQ_out (sram2_dq_out),
        .SRAM_DQ_in  (sram2_dq_in),
        .SRAM_DQ_oe  (sram2_dq_oe),
        .SRAM_WE_N   (sram2_we_n),
        .SRAM_OE_N   (sram2_oe_n)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model for the first instance: latches a half-word whenever the write strobe is low
    always @(posedge clk) begin
        if (!sram1_we_n) mem1[sram1_addr[7:0]] <= sram1_dq_out;
    end

    assign sram1_dq_in = sram1_oe_n ? 16'h0000 : mem1[sram1_addr[7:0]];
    assign sram2_dq_in = sram2_oe_n ? 16'h0000 : mem2[sram2_addr[7:0]];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic rd, input logic wr,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        bus1.MEMread  = rd;
        bus1.MEMwrite = wr;
        bus1.address  = addr;
        bus1.data     = wdata;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Directed sequence covering reset, write, read, simultaneous request, mid-read reset and back-to-back reads
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
        bus2.MEMread  = 1'b0;
        bus2.MEMwrite = 1'b0;
        bus2.address  = 32'd0;
        bus2.data     = 32'd0;
        for (int i = 0; i < 256; i++) begin
            mem2[i] = 16'h0000;
        end
        mem2[0] = 16'h1111;
        mem2[1] = 16'h2222;
        mem2[4] = 16'h3333;
        mem2[5] = 16'h4444;

        repeat (2) next_cycle();
        rst = 1'b1;
        next_cycle();

        $display("[TB] reset release");
        check_output("rst_ready",  32'(bus1.ready), 32'd1);
        check_output("rst_we_n",   32'(sram1_we_n), 32'd1);
        check_output("rst_oe_n",   32'(sram1_oe_n), 32'd1);
        check_output("rst_dq_oe",  32'(sram1_dq_oe), 32'd0);
        check_output("rst_result", bus1.MEM_result, 32'h0);
        check_output("rst_addr",   32'(sram1_addr), 32'd0);

        $display("[TB] write 0xDEADBEEF at 1028");
        apply_stimulus(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        #1 check_output("wr_c0_ready", 32'(bus1.ready), 32'd0);
        next_cycle();
        check_output("wr_c1_addr",  32'(sram1_addr), 32'd2);
        check_output("wr_c1_dq",    32'(sram1_dq_out), 32'h0000BEEF);
        check_output("wr_c1_we_n",  32'(sram1_we_n), 32'd0);
        check_output("wr_c1_dq_oe", 32'(sram1_dq_oe), 32'd1);
        check_output("wr_c1_ready", 32'(bus1.ready), 32'd0);
        next_cycle();
        check_output("wr_c2_addr",  32'(sram1_addr), 32'd2);
        check_output("wr_c2_we_n",  32'(sram1_we_n), 32'd1);
        check_output("wr_c2_dq_oe", 32'(sram1_dq_oe), 32'd1);
        next_cycle();
        check_output("wr_c3_addr",  32'(sram1_addr), 32'd3);
        check_output("wr_c3_dq",    32'(sram1_dq_out), 32'h0000DEAD);
        check_output("wr_c3_we_n",  32'(sram1_we_n), 32'd0);
        next_cycle();
        check_output("wr_c4_we_n",  32'(sram1_we_n), 32'd1);
        check_output("wr_c4_ready", 32'(bus1.ready), 32'd0);
        next_cycle();
        check_output("wr_c5_ready", 32'(bus1.ready), 32'd1);
        check_output("wr_c5_dq_oe", 32'(sram1_dq_oe), 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
        next_cycle();
        check_output("wr_c6_ready", 32'(bus1.ready), 32'd1);

        $display("[TB] read back at 1028");
        apply_stimulus(1'b1, 1'b0, 32'd1028, 32'd0);
        #1 check_output("rd_c0_ready", 32'(bus1.ready), 32'd0);
        next_cycle();
        check_output("rd_c1_addr",  32'(sram1_addr), 32'd2);
        check_output("rd_c1_oe_n",  32'(sram1_oe_n), 32'd0);
        check_output("rd_c1_dq_oe", 32'(sram1_dq_oe), 32'd0);
        check_output("rd_c1_we_n",  32'(sram1_we_n), 32'd1);
        next_cycle();
        next_cycle();
        check_output("rd_c3_addr",  32'(sram1_addr), 32'd3);
        next_cycle();
        check_output("rd_c4_ready", 32'(bus1.ready), 32'd0);
        next_cycle();
        check_output("rd_c5_ready",  32'(bus1.ready), 32'd1);
        check_output("rd_c5_result", bus1.MEM_result, 32'hDEADBEEF);
        apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
        next_cycle();

        $display("[TB] read and write together at 1036");
        apply_stimulus(1'b1, 1'b1, 32'd1036, 32'h12345678);
        next_cycle();
        check_output("both_c1_addr", 32'(sram1_addr), 32'd6);
        check_output("both_c1_we_n", 32'(sram1_we_n), 32'd0);
        check_output("both_c1_oe_n", 32'(sram1_oe_n), 32'd1);
        check_output("both_c1_dq",   32'(sram1_dq_out), 32'h00005678);
        next_cycle();
        next_cycle();
        check_output("both_c3_addr", 32'(sram1_addr), 32'd7);
        check_output("both_c3_dq",   32'(sram1_dq_out), 32'h00001234);
        next_cycle();
        next_cycle();
        check_output("both_c5_ready",  32'(bus1.ready), 32'd1);
        check_output("both_c5_result", bus1.MEM_result, 32'hDEADBEEF);
        check_output("both_mem_lo",    32'(mem1[6]), 32'h00005678);
        check_output("both_mem_hi",    32'(mem1[7]), 32'h00001234);
        apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
        next_cycle();

        $display("[TB] reset during RD_HI");
        apply_stimulus(1'b1, 1'b0, 32'd1036, 32'd0);
        next_cycle();
        next_cycle();
        next_cycle();
        check_output("mid_c3_oe_n", 32'(sram1_oe_n), 32'd0);
        check_output("mid_c3_addr", 32'(sram1_addr), 32'd7);
        #2 rst = 1'b0;
        #1;
        check_output("mid_rst_oe_n",   32'(sram1_oe_n), 32'd1);
        check_output("mid_rst_addr",   32'(sram1_addr), 32'd0);
        check_output("mid_rst_result", bus1.MEM_result, 32'h0);
        check_output("mid_rst_ready",  32'(bus1.ready), 32'd0);
        apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
        #1 check_output("mid_rst_idle_ready", 32'(bus1.ready), 32'd1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        apply_stimulus(1'b1, 1'b0, 32'd1036, 32'd0);
        #1 check_output("post_c0_ready", 32'(bus1.ready), 32'd0);
        next_cycle();
        next_cycle();
        next_cycle();
        next_cycle();
        check_output("post_c4_ready", 32'(bus1.ready), 32'd0);
        next_cycle();
        check_output("post_c5_ready",  32'(bus1.ready), 32'd1);
        check_output("post_c5_result", bus1.MEM_result, 32'h12345678);
        apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
        next_cycle();

        $display("[TB] single wait cycle, back-to-back reads at 1024 and 1032");
        bus2.MEMread = 1'b1;
        bus2.address = 32'd1024;
        #1 check_output("b2b_c0_ready", 32'(bus2.ready), 32'd0);
        next_cycle();
        check_output("b2b_c1_addr", 32'(sram2_addr), 32'd0);
        check_output("b2b_c1_oe_n", 32'(sram2_oe_n), 32'd0);
        next_cycle();
        check_output("b2b_c2_addr",  32'(sram2_addr), 32'd1);
        check_output("b2b_c2_ready", 32'(bus2.ready), 32'd0);
        next_cycle();
        check_output("b2b_c3_ready",  32'(bus2.ready), 32'd1);
        check_output("b2b_c3_result", bus2.MEM_result, 32'h22221111);
        bus2.address = 32'd1032;
        next_cycle();
        check_output("b2b_c4_ready", 32'(bus2.ready), 32'd0);
        next_cycle();
        check_output("b2b_c5_addr", 32'(sram2_addr), 32'd4);
        next_cycle();
        check_output("b2b_c6_addr",  32'(sram2_addr), 32'd5);
        check_output("b2b_c6_ready", 32'(bus2.ready), 32'd0);
        next_cycle();
        check_output("b2b_c7_ready",  32'(bus2.ready), 32'd1);
        check_output("b2b_c7_result", bus2.MEM_result, 32'h44443333);
        check_output("b2b_c7_we_n",   32'(sram2_we_n), 32'd1);
        bus2.MEMread = 1'b0;
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
